// File: rtl/fsk_sequencer.sv
// FSK byte sequencer on the PIC expansion bus.
// Frames each held byte (start, 8 data LSB-first, stop) and drives the DDS tone step and enable.
module fsk_sequencer #(
  parameter logic [6:0]  BASE_ADDR = 7'h79,
  parameter int unsigned PRESCALE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] expdin,
  input  logic [7:0] expdout,
  input  logic [6:0] expaddr,
  input  logic       expread,
  input  logic       expwrite,
  output logic [7:0] ddsstep_out,
  output logic       dds_en,
  output logic       busy,
  output logic       txdone
);

  localparam int unsigned   PW      = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    r_state;
  logic          r_en;
  logic          r_idlecar;
  logic [7:0]    r_mark;
  logic [7:0]    r_space;
  logic [7:0]    r_baud;
  logic [7:0]    r_hold;
  logic          r_hfull;
  logic          r_ovr;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitcnt;
  logic [PW-1:0] r_pre;
  logic [7:0]    r_bcnt;
  logic [7:0]    r_step;
  logic          r_dds_en;
  logic          r_txdone;

  logic [1:0]    w_state_nxt;
  logic          w_load;
  logic          w_done;
  logic [7:0]    w_tone;
  logic [6:0]    w_off;
  logic          w_sel;
  logic          w_wr;
  logic          w_rd;
  logic          w_wr_data;
  logic          w_rd_stat;
  logic          w_tick;
  logic          w_bit_end;

  // Address decode: offset relative to the register window.
  assign w_off     = 7'(expaddr - BASE_ADDR);
  assign w_sel     = (w_off < 7'd5);
  assign w_wr      = expwrite & w_sel;
  assign w_rd      = expread & w_sel;
  assign w_wr_data = w_wr & (w_off == 7'd4);
  assign w_rd_stat = w_rd & (w_off == 7'd4);

  // Bit ends on a prescale tick once the baud count has reached BAUD (>= tolerates BAUD shrinking).
  assign w_tick    = (r_pre == PRE_MAX);
  assign w_bit_end = w_tick & (r_bcnt >= r_baud);

  assign busy        = (r_state != S_IDLE);
  assign ddsstep_out = r_step;
  assign dds_en      = r_dds_en;
  assign txdone      = r_txdone;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    w_tone      = 8'h00;
    case (r_state)
      S_IDLE: begin
        w_tone = (r_en & r_idlecar) ? r_mark : 8'h00;
        if (r_en && r_hfull) begin
          w_load      = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tone = r_space;
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tone = r_shift[0] ? r_mark : r_space;
        if (w_bit_end && (r_bitcnt == 3'd7)) w_state_nxt = S_STOP;
      end
      default: begin
        w_tone = r_mark;
        if (w_bit_end) begin
          w_done = 1'b1;
          if (r_en && r_hfull) begin
            w_load      = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
    endcase
    // Dropping EN abandons the frame without a txdone and leaves the holding register alone.
    if (!r_en) begin
      w_state_nxt = S_IDLE;
      w_load      = 1'b0;
      w_done      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en      <= 1'b0;
      r_idlecar <= 1'b0;
      r_mark    <= 8'h00;
      r_space   <= 8'h00;
      r_baud    <= 8'h00;
    end else if (w_wr) begin
      case (w_off)
        7'd0:    {r_idlecar, r_en} <= expdout[1:0];
        7'd1:    r_mark  <= expdout;
        7'd2:    r_space <= expdout;
        7'd3:    r_baud  <= expdout;
        default: ;
      endcase
    end
  end

  // Holding register: a load on the same edge as a data write frees the slot for that write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold  <= 8'h00;
      r_hfull <= 1'b0;
      r_ovr   <= 1'b0;
      r_shift <= 8'h00;
    end else begin
      if (w_rd_stat) r_ovr <= 1'b0;
      if (w_load) begin
        r_shift <= r_hold;
        r_hfull <= w_wr_data;
        if (w_wr_data) r_hold <= expdout;
      end else begin
        if (r_state == S_DATA && w_bit_end) r_shift <= {1'b0, r_shift[7:1]};
        if (w_wr_data) begin
          if (r_hfull) begin
            r_ovr <= 1'b1;
          end else begin
            r_hold  <= expdout;
            r_hfull <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre    <= '0;
      r_bcnt   <= 8'h00;
      r_bitcnt <= 3'd0;
    end else begin
      if (w_load || !r_en || (r_state == S_IDLE) || w_bit_end) begin
        r_pre  <= '0;
        r_bcnt <= 8'h00;
      end else if (w_tick) begin
        r_pre  <= '0;
        r_bcnt <= 8'(r_bcnt + 8'd1);
      end else begin
        r_pre  <= PW'(r_pre + 1'b1);
      end
      if (w_load || (r_state == S_START)) r_bitcnt <= 3'd0;
      else if (r_state == S_DATA && w_bit_end) r_bitcnt <= 3'(r_bitcnt + 3'd1);
    end
  end

  // DDS outputs lag the state by one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step   <= 8'h00;
      r_dds_en <= 1'b0;
      r_txdone <= 1'b0;
    end else begin
      r_step   <= w_tone;
      r_dds_en <= r_en & (r_idlecar | (r_state != S_IDLE));
      r_txdone <= w_done;
    end
  end

  always_comb begin
    expdin = 8'h00;
    if (w_rd) begin
      case (w_off)
        7'd0:    expdin = {6'b0, r_idlecar, r_en};
        7'd1:    expdin = r_mark;
        7'd2:    expdin = r_space;
        7'd3:    expdin = r_baud;
        7'd4:    expdin = {5'b0, r_ovr, r_hfull, busy};
        default: expdin = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_sequencer.sv
// Scoreboard bench for fsk_sequencer: stimulus queues expectations, one monitor compares them.
module tb_fsk_sequencer;

  localparam logic [6:0] B  = 7'h79;
  localparam logic [7:0] MK = 8'h20;
  localparam logic [7:0] SP = 8'h10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] expdin;
  logic [7:0] expdout = 8'h00;
  logic [6:0] expaddr = 7'h00;
  logic       expread = 1'b0;
  logic       expwrite = 1'b0;
  logic [7:0] ddsstep_out;
  logic       dds_en;
  logic       busy;
  logic       txdone;

  fsk_sequencer #(.BASE_ADDR(B), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .expdin(expdin), .expdout(expdout), .expaddr(expaddr),
    .expread(expread), .expwrite(expwrite), .ddsstep_out(ddsstep_out), .dds_en(dds_en),
    .busy(busy), .txdone(txdone)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    v;
  } exp_t;

  exp_t q_rd[$];
  exp_t q_tone[$];
  exp_t q_done[$];
  exp_t q_busy[$];
  exp_t q_snap[$];
  exp_t q_rst[$];

  int total = 0;
  int bad = 0;
  int to_pend = 0;
  int to_ack = 0;
  bit fin = 1'b0;
  bit fin_ack = 1'b0;

  int m_cyc = 0;
  int m_ref = 0;
  int m_run = 0;
  int m_tpos = 0;
  bit m_pb = 1'b0;

  function automatic exp_t mk(string nm, int v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    return e;
  endfunction

  function automatic int outs(logic b, logic e, logic t, logic [7:0] s);
    return int'({b, e, t, s});
  endfunction

  task automatic chk(string nm, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic unexpected(string nm, int act);
    total++;
    bad++;
    $display("FAIL %s: got %0h want nothing", nm, act);
  endtask

  // Monitor: samples 1ns after each falling edge, or 1ns after reset rises with no clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge reset);
      #1;
      if (reset) begin
        if (q_rst.size() > 0) begin
          e = q_rst.pop_front();
          chk(e.nm, outs(busy, dds_en, txdone, ddsstep_out), e.v);
          chk({e.nm, "_expdin"}, int'(expdin), 0);
        end
        m_run = 0; m_tpos = 0; m_pb = 1'b0;
      end else begin
        m_cyc++;
        if (q_snap.size() > 0) begin
          e = q_snap.pop_front();
          chk(e.nm, outs(busy, dds_en, txdone, ddsstep_out), e.v);
        end
        if (expread) begin
          if (q_rd.size() > 0) begin
            e = q_rd.pop_front();
            chk(e.nm, int'(expdin), e.v);
          end else unexpected("unexpected_read", int'(expdin));
        end
        if (m_pb) begin
          if ((m_tpos % 8) == 4 && q_tone.size() > 0) begin
            e = q_tone.pop_front();
            chk(e.nm, int'(ddsstep_out), e.v);
          end
          m_tpos++;
        end else m_tpos = 0;
        if (busy) begin
          if (!m_pb) m_ref = m_cyc;
          m_run++;
        end else if (m_run > 0) begin
          if (q_busy.size() > 0) begin
            e = q_busy.pop_front();
            chk(e.nm, m_run, e.v);
          end else unexpected("unexpected_busy_run", m_run);
          m_run = 0;
        end
        if (txdone) begin
          if (q_done.size() > 0) begin
            e = q_done.pop_front();
            chk(e.nm, m_cyc - m_ref, e.v);
          end else unexpected("unexpected_txdone", m_cyc - m_ref);
          m_ref = m_cyc;
        end
        if (to_pend != to_ack) begin
          unexpected("wait_timeout", to_pend);
          to_ack = to_pend;
        end
        m_pb = busy;
        if (fin && !fin_ack) begin
          chk("queues_drained", q_rd.size() + q_tone.size() + q_done.size() + q_busy.size()
              + q_snap.size() + q_rst.size(), 0);
          fin_ack = 1'b1;
        end
      end
    end
  end

  task automatic wr(logic [6:0] a, logic [7:0] d);
    expaddr = a; expdout = d; expwrite = 1'b1;
    @(negedge clk);
    expwrite = 1'b0;
  endtask

  task automatic rd(logic [6:0] a, int want, string nm);
    expaddr = a; expread = 1'b1;
    q_rd.push_back(mk(nm, want));
    @(negedge clk);
    expread = 1'b0;
  endtask

  task automatic push_byte(logic [7:0] b, string nm);
    q_tone.push_back(mk({nm, "_start"}, int'(SP)));
    for (int i = 0; i < 8; i++) q_tone.push_back(mk($sformatf("%s_d%0d", nm, i), int'(b[i] ? MK : SP)));
    q_tone.push_back(mk({nm, "_stop"}, int'(MK)));
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 50) begin @(negedge clk); n++; end
    if (!busy) to_pend++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    if (busy) to_pend++;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // Reset state
    q_snap.push_back(mk("reset_outputs", outs(0, 0, 0, 8'h00)));
    for (int i = 0; i < 5; i++) rd(7'(B + 7'(i)), 0, $sformatf("reset_reg%0d", i));

    // Register access, masked CTL bits and unmapped window
    wr(B + 7'd1, MK); wr(B + 7'd2, SP); wr(B + 7'd3, 8'h01); wr(B, 8'hFF);
    wr(7'h7E, 8'h55); wr(7'h78, 8'h66);
    rd(B, 8'h03, "ctl_readback"); rd(B + 7'd1, MK, "mark_readback");
    rd(B + 7'd2, SP, "space_readback"); rd(B + 7'd3, 8'h01, "baud_readback");
    rd(7'h78, 0, "unmapped_read");
    wr(B, 8'h01);

    // Single byte A5
    push_byte(8'hA5, "a5");
    q_done.push_back(mk("a5_txdone_gap", 80));
    q_busy.push_back(mk("a5_busy_len", 80));
    wr(B + 7'd4, 8'hA5);
    wait_busy(); wait_idle();
    rd(B + 7'd4, 0, "status_after_a5");

    // Back-to-back 55 then AA
    push_byte(8'h55, "b55"); push_byte(8'hAA, "baa");
    q_done.push_back(mk("b55_txdone_gap", 80)); q_done.push_back(mk("baa_txdone_gap", 80));
    q_busy.push_back(mk("b2b_busy_len", 160));
    wr(B + 7'd4, 8'h55);
    wait_busy(); repeat (5) @(negedge clk);
    wr(B + 7'd4, 8'hAA);
    wait_idle();
    rd(B + 7'd4, 0, "status_b2b_no_ovr");

    // Overrun: third byte dropped
    push_byte(8'h0F, "o0f"); push_byte(8'hF0, "of0");
    q_done.push_back(mk("o0f_txdone_gap", 80)); q_done.push_back(mk("of0_txdone_gap", 80));
    q_busy.push_back(mk("ovr_busy_len", 160));
    wr(B + 7'd4, 8'h0F);
    wait_busy();
    wr(B + 7'd4, 8'hF0); wr(B + 7'd4, 8'h33);
    rd(B + 7'd4, 8'h07, "status_ovr");
    rd(B + 7'd4, 8'h03, "status_ovr_cleared");
    wait_idle();
    rd(B + 7'd4, 0, "status_after_ovr");

    // Abort by clearing EN during data bit 3 of 3C; 99 stays held
    q_busy.push_back(mk("abort_busy_len", 38));
    wr(B + 7'd4, 8'h3C);
    wait_busy();
    wr(B + 7'd4, 8'h99);
    repeat (35) @(negedge clk);
    wr(B, 8'h00);
    q_snap.push_back(mk("abort_en_clear", outs(1, 1, 0, MK)));
    @(negedge clk);
    q_snap.push_back(mk("abort_next", outs(0, 0, 0, MK)));
    @(negedge clk);
    q_snap.push_back(mk("abort_idle", outs(0, 0, 0, 8'h00)));
    @(negedge clk);
    rd(B + 7'd4, 8'h02, "status_abort_hold_kept");

    // Idle carrier
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    wr(B + 7'd1, MK); wr(B + 7'd2, SP); wr(B + 7'd3, 8'h01); wr(B, 8'h03);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      q_snap.push_back(mk($sformatf("idlecar_%0d", i), outs(0, 1, 0, MK)));
      @(negedge clk);
    end

    // Async reset mid-frame
    wr(B + 7'd4, 8'hA5);
    wait_busy();
    repeat (20) @(negedge clk);
    #3;
    q_rst.push_back(mk("async_reset_outputs", outs(0, 0, 0, 8'h00)));
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(B, 0, "ctl_after_async_reset");
    rd(B + 7'd4, 0, "status_after_async_reset");

    fin = 1'b1;
    n = 0;
    while (!fin_ack && n < 10) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
